dual_port_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's two memory ports: instruction port (readM1/address1/data1)
//  and data port (readM2/writeM2/address2/data2, bidirectional). Each port runs an independent

---
 rtl/dual_port_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_dual_port_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem_responder.sv
// Memory-side responder for the CPU instruction port (1) and data port (2).
// Each port runs an independent fixed-latency FSM and pulses ready when its access completes.
`timescale 1ns/1ps

module dual_port_mem_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        readM1,
    input  logic [15:0] address1,
    output logic [15:0] data1,
    output logic        ready1,
    input  logic        readM2,
    input  logic        writeM2,
    input  logic [15:0] address2,
    inout  wire  [15:0] data2,
    output logic        ready2
);

    localparam int WordSize = 16;
    localparam int Depth    = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        Idle,
        Busy,
        Done
    } state_t;

    logic [WordSize-1:0] mem [Depth];

    // Address bits above the array index alias onto the same words.
    logic unusedAddrBits;
    assign unusedAddrBits = &{1'b0, address1[15:ADDR_BITS], address2[15:ADDR_BITS]};

    if (LATENCY == 0) begin : gComb
        logic unusedReadM1;
        assign unusedReadM1 = readM1;

        always_ff @(posedge clk) begin
            if (writeM2) begin
                mem[address2[ADDR_BITS-1:0]] <= data2;
            end
        end

        assign data1  = mem[address1[ADDR_BITS-1:0]];
        assign data2  = (readM2 && !writeM2) ? mem[address2[ADDR_BITS-1:0]] : 'z;
        assign ready1 = reset_n;
        assign ready2 = reset_n;
    end else begin : gSeq
        localparam int CntW = $clog2(LATENCY + 1);

        state_t               state1_q, state1_d, state2_q, state2_d;
        logic [CntW-1:0]      cnt1_q, cnt1_d, cnt2_q, cnt2_d;
        logic [ADDR_BITS-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
        logic                 isWrite2_q, isWrite2_d;
        logic [WordSize-1:0]  wrData2_q, wrData2_d;
        logic [WordSize-1:0]  rdData1_q, rdData2_q;
        logic                 capture1, commit2;

        always_comb begin
            state1_d = state1_q;
            cnt1_d   = cnt1_q;
            idx1_d   = idx1_q;
            capture1 = 1'b0;
            unique case (state1_q)
                Idle, Done: begin
                    if (readM1) begin
                        idx1_d   = address1[ADDR_BITS-1:0];
                        cnt1_d   = CntW'(LATENCY);
                        state1_d = Busy;
                    end else begin
                        state1_d = Idle;
                    end
                end
                Busy: begin
                    cnt1_d = cnt1_q - 1'b1;
                    if (cnt1_q == CntW'(1)) begin
                        capture1 = 1'b1;
                        state1_d = Done;
                    end
                end
                default: state1_d = Idle;
            endcase
        end

        always_comb begin
            state2_d   = state2_q;
            cnt2_d     = cnt2_q;
            idx2_d     = idx2_q;
            isWrite2_d = isWrite2_q;
            wrData2_d  = wrData2_q;
            commit2    = 1'b0;
            unique case (state2_q)
                Idle, Done: begin
                    if (readM2 || writeM2) begin
                        idx2_d     = address2[ADDR_BITS-1:0];
                        isWrite2_d = writeM2;
                        if (writeM2) begin
                            wrData2_d = data2;
                        end
                        cnt2_d   = CntW'(LATENCY);
                        state2_d = Busy;
                    end else begin
                        state2_d = Idle;
                    end
                end
                Busy: begin
                    cnt2_d = cnt2_q - 1'b1;
                    if (cnt2_q == CntW'(1)) begin
                        commit2  = 1'b1;
                        state2_d = Done;
                    end
                end
                default: state2_d = Idle;
            endcase
        end

        // Port-1 capture reads the array before this edge's port-2 write lands (read-first).
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state1_q   <= Idle;
                cnt1_q     <= '0;
                idx1_q     <= '0;
                rdData1_q  <= '0;
                state2_q   <= Idle;
                cnt2_q     <= '0;
                idx2_q     <= '0;
                isWrite2_q <= 1'b0;
                wrData2_q  <= '0;
                rdData2_q  <= '0;
            end else begin
                state1_q   <= state1_d;
                cnt1_q     <= cnt1_d;
                idx1_q     <= idx1_d;
                state2_q   <= state2_d;
                cnt2_q     <= cnt2_d;
                idx2_q     <= idx2_d;
                isWrite2_q <= isWrite2_d;
                wrData2_q  <= wrData2_d;
                if (capture1) begin
                    rdData1_q <= mem[idx1_q];
                end
                if (commit2 && !isWrite2_q) begin
                    rdData2_q <= mem[idx2_q];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (commit2 && isWrite2_q) begin
                mem[idx2_q] <= wrData2_q;
            end
        end

        assign data1  = rdData1_q;
        assign ready1 = (state1_q == Done);
        assign ready2 = (state2_q == Done);
        assign data2  = ((state2_q == Done) && !isWrite2_q && readM2 && !writeM2) ? rdData2_q : 'z;
    end

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Directed bench for dual_port_mem_responder at LATENCY 2, 1 and 0.
// The main data2 bus carries a pullup, so an undriven bus reads as 16'hFFFF.
`timescale 1ns/1ps

module tb_dual_port_mem_responder;

    localparam logic [15:0] BusIdle = 16'hFFFF;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic        readM1, readM2, writeM2, ready1, ready2, tbDrive;
    logic [15:0] address1, address2, data1, tbData;
    wire  [15:0] data2;

    logic        l1ReadM1, l1ReadM2, l1WriteM2, l1Ready1, l1Ready2, l1TbDrive;
    logic [15:0] l1Address1, l1Address2, l1Data1, l1TbData;
    wire  [15:0] l1Data2;

    logic        l0ReadM1, l0ReadM2, l0WriteM2, l0Ready1, l0Ready2, l0TbDrive;
    logic [15:0] l0Address1, l0Address2, l0Data1, l0TbData;
    wire  [15:0] l0Data2;

    assign data2   = tbDrive   ? tbData   : 16'hzzzz;
    assign l1Data2 = l1TbDrive ? l1TbData : 16'hzzzz;
    assign l0Data2 = l0TbDrive ? l0TbData : 16'hzzzz;
    pullup (data2);

    dual_port_mem_responder #(.LATENCY(2), .ADDR_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .readM1(readM1), .address1(address1), .data1(data1), .ready1(ready1),
        .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2), .ready2(ready2)
    );

    dual_port_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dutL1 (
        .clk(clk), .reset_n(reset_n),
        .readM1(l1ReadM1), .address1(l1Address1), .data1(l1Data1), .ready1(l1Ready1),
        .readM2(l1ReadM2), .writeM2(l1WriteM2), .address2(l1Address2), .data2(l1Data2),
        .ready2(l1Ready2)
    );

    dual_port_mem_responder #(.LATENCY(0), .ADDR_BITS(8)) dutL0 (
        .clk(clk), .reset_n(reset_n),
        .readM1(l0ReadM1), .address1(l0Address1), .data1(l0Data1), .ready1(l0Ready1),
        .readM2(l0ReadM2), .writeM2(l0WriteM2), .address2(l0Address2), .data2(l0Data2),
        .ready2(l0Ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full LATENCY=2 port-2 write: accept, two busy edges, then back to idle.
    task automatic write2(input logic [15:0] a, input logic [15:0] d);
        writeM2 = 1'b1; address2 = a; tbData = d; tbDrive = 1'b1;
        tick();
        writeM2 = 1'b0; tbDrive = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic read1(input logic [15:0] a);
        readM1 = 1'b1; address1 = a;
        tick();
        readM1 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        readM1 = 0; readM2 = 0; writeM2 = 0; address1 = 0; address2 = 0; tbData = 0; tbDrive = 0;
        l1ReadM1 = 0; l1ReadM2 = 0; l1WriteM2 = 0; l1Address1 = 0; l1Address2 = 0;
        l1TbData = 0; l1TbDrive = 0;
        l0ReadM1 = 0; l0ReadM2 = 0; l0WriteM2 = 0; l0Address1 = 0; l0Address2 = 0;
        l0TbData = 0; l0TbDrive = 0;
        #2;
        checks++;
        if (ready1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready1 got %b expected 0", ready1); end
        checks++;
        if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready2 got %b expected 0", ready2); end
        checks++;
        if (data1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data1 got %h expected 0000", data1); end
        checks++;
        if (data2 !== BusIdle) begin errors++; $display("[TB] FAIL reset_data2 got %h expected %h", data2, BusIdle); end
        checks++;
        if (l0Ready1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_l0_ready1 got %b expected 0", l0Ready1); end
        tick(); tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (l0Ready1 !== 1'b1) begin errors++; $display("[TB] FAIL l0_ready1_out_of_reset got %b expected 1", l0Ready1); end
        checks++;
        if (ready1 !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready1 got %b expected 0", ready1); end
    endtask

    task automatic test_read_latency();
        write2(16'h0010, 16'h1234);
        readM1 = 1'b1; address1 = 16'h0010;
        tick();
        checks++;
        if (ready1 !== 1'b0) begin errors++; $display("[TB] FAIL lat_edge0_ready1 got %b expected 0", ready1); end
        readM1 = 1'b0; address1 = 16'h00AA;
        tick();
        checks++;
        if (ready1 !== 1'b0) begin errors++; $display("[TB] FAIL lat_edge1_ready1 got %b expected 0", ready1); end
        tick();
        checks++;
        if (ready1 !== 1'b1) begin errors++; $display("[TB] FAIL lat_edge2_ready1 got %b expected 1", ready1); end
        checks++;
        if (data1 !== 16'h1234) begin errors++; $display("[TB] FAIL lat_edge2_data1 got %h expected 1234", data1); end
        tick();
        checks++;
        if (ready1 !== 1'b0) begin errors++; $display("[TB] FAIL lat_edge3_ready1 got %b expected 0", ready1); end
        checks++;
        if (data1 !== 16'h1234) begin errors++; $display("[TB] FAIL lat_hold_data1 got %h expected 1234", data1); end
    endtask

    task automatic test_write_read2();
        writeM2 = 1'b1; address2 = 16'h0020; tbData = 16'hBEEF; tbDrive = 1'b1;
        tick();
        writeM2 = 1'b0; tbDrive = 1'b0;
        #1;
        checks++;
        if (data2 !== BusIdle) begin errors++; $display("[TB] FAIL wr_busy0_data2 got %h expected %h", data2, BusIdle); end
        tick();
        checks++;
        if (ready2 !== 1'b0 || data2 !== BusIdle) begin
            errors++; $display("[TB] FAIL wr_busy1 ready2 %b data2 %h expected 0 %h", ready2, data2, BusIdle);
        end
        tick();
        checks++;
        if (ready2 !== 1'b1) begin errors++; $display("[TB] FAIL wr_done_ready2 got %b expected 1", ready2); end
        readM2 = 1'b1;
        #1;
        checks++;
        if (data2 !== BusIdle) begin errors++; $display("[TB] FAIL wr_done_data2 got %h expected %h", data2, BusIdle); end
        readM2 = 1'b0;
        tick();
        readM2 = 1'b1; address2 = 16'h0020;
        tick();
        readM2 = 1'b0;
        tick(); tick();
        checks++;
        if (ready2 !== 1'b1) begin errors++; $display("[TB] FAIL rd2_done_ready2 got %b expected 1", ready2); end
        readM2 = 1'b1;
        #1;
        checks++;
        if (data2 !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd2_data2 got %h expected BEEF", data2); end
        readM2 = 1'b0;
        #1;
        checks++;
        if (data2 !== BusIdle) begin errors++; $display("[TB] FAIL rd2_release got %h expected %h", data2, BusIdle); end
        tick();
    endtask

    task automatic test_collision();
        write2(16'h0030, 16'h0001);
        writeM2 = 1'b1; address2 = 16'h0030; tbData = 16'h00FF; tbDrive = 1'b1;
        readM1 = 1'b1; address1 = 16'h0030;
        tick();
        writeM2 = 1'b0; tbDrive = 1'b0; readM1 = 1'b0;
        tick(); tick();
        checks++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
            errors++; $display("[TB] FAIL coll_ready got %b%b expected 11", ready1, ready2);
        end
        checks++;
        if (data1 !== 16'h0001) begin errors++; $display("[TB] FAIL coll_old_value got %h expected 0001", data1); end
        tick();
        read1(16'h0030);
        checks++;
        if (data1 !== 16'h00FF) begin errors++; $display("[TB] FAIL coll_new_value got %h expected 00FF", data1); end
    endtask

    task automatic test_both_requests();
        readM2 = 1'b1; writeM2 = 1'b1; address2 = 16'h0040; tbData = 16'h5A5A; tbDrive = 1'b1;
        tick();
        readM2 = 1'b0; writeM2 = 1'b0; tbDrive = 1'b0;
        #1;
        checks++;
        if (data2 !== BusIdle) begin errors++; $display("[TB] FAIL both_busy0_data2 got %h expected %h", data2, BusIdle); end
        tick(); tick();
        checks++;
        if (ready2 !== 1'b1) begin errors++; $display("[TB] FAIL both_ready2 got %b expected 1", ready2); end
        readM2 = 1'b1;
        #1;
        checks++;
        if (data2 !== BusIdle) begin errors++; $display("[TB] FAIL both_done_data2 got %h expected %h", data2, BusIdle); end
        readM2 = 1'b0;
        tick();
        read1(16'h0040);
        checks++;
        if (data1 !== 16'h5A5A) begin errors++; $display("[TB] FAIL both_mem got %h expected 5A5A", data1); end
    endtask

    task automatic test_reset_mid_write();
        write2(16'h0050, 16'h0003);
        writeM2 = 1'b1; address2 = 16'h0050; tbData = 16'h7777; tbDrive = 1'b1;
        tick();
        writeM2 = 1'b0; tbDrive = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ready2 got %b expected 0", ready2); end
        checks++;
        if (data1 !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mid_data1 got %h expected 0000", data1); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_ready2 got %b expected 0", ready2); end
        read1(16'h0050);
        checks++;
        if (data1 !== 16'h0003) begin errors++; $display("[TB] FAIL rst_discard got %h expected 0003", data1); end
    endtask

    task automatic test_alias();
        write2(16'h0010, 16'hCAFE);
        read1(16'h0110);
        checks++;
        if (data1 !== 16'hCAFE) begin errors++; $display("[TB] FAIL alias got %h expected CAFE", data1); end
    endtask

    task automatic test_back_to_back();
        l1WriteM2 = 1'b1; l1Address2 = 16'h0005; l1TbData = 16'h1111; l1TbDrive = 1'b1;
        tick();
        l1WriteM2 = 1'b0; l1TbDrive = 1'b0;
        tick();
        checks++;
        if (l1Ready2 !== 1'b1) begin errors++; $display("[TB] FAIL l1_write_ready2 got %b expected 1", l1Ready2); end
        tick();
        l1ReadM1 = 1'b1; l1Address1 = 16'h0005;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (l1Ready1 !== 1'(i % 2)) begin
                errors++; $display("[TB] FAIL l1_b2b_ready1 edge %0d got %b expected %0d", i, l1Ready1, i % 2);
            end
            if (i % 2 == 1) begin
                checks++;
                if (l1Data1 !== 16'h1111) begin
                    errors++; $display("[TB] FAIL l1_b2b_data1 edge %0d got %h expected 1111", i, l1Data1);
                end
            end
        end
        l1ReadM1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_zero_latency();
        l0WriteM2 = 1'b1; l0Address2 = 16'h000A; l0TbData = 16'hAAAA; l0TbDrive = 1'b1;
        tick();
        l0Address2 = 16'h000B; l0TbData = 16'hBBBB;
        tick();
        l0WriteM2 = 1'b0; l0TbDrive = 1'b0;
        l0Address1 = 16'h000A;
        #1;
        checks++;
        if (l0Data1 !== 16'hAAAA) begin errors++; $display("[TB] FAIL l0_data1_a got %h expected AAAA", l0Data1); end
        l0Address1 = 16'h010B;
        #1;
        checks++;
        if (l0Data1 !== 16'hBBBB) begin errors++; $display("[TB] FAIL l0_data1_b got %h expected BBBB", l0Data1); end
        checks++;
        if (l0Ready1 !== 1'b1 || l0Ready2 !== 1'b1) begin
            errors++; $display("[TB] FAIL l0_ready got %b%b expected 11", l0Ready1, l0Ready2);
        end
        l0ReadM2 = 1'b1; l0Address2 = 16'h000A;
        #1;
        checks++;
        if (l0Data2 !== 16'hAAAA) begin errors++; $display("[TB] FAIL l0_data2 got %h expected AAAA", l0Data2); end
        l0ReadM2 = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_latency();
        test_write_read2();
        test_collision();
        test_both_requests();
        test_reset_mid_write();
        test_alias();
        test_back_to_back();
        test_zero_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
